// File: rtl/instr_ram_loader.sv
// Instruction-memory loader: streams words over valid/ready into a synchronous RAM
// at an auto-incrementing cursor, with a registered read port for the fetch stage.
module instr_ram_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int WRAP_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  load_end,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  full,
    output logic                  overflow,
    output logic                  done,
    output logic                  busy
);

    // state  | meaning
    // S_IDLE | no session since reset
    // S_LOAD | accepting words at the cursor
    // S_FULL | last address written (stop mode), further offers flag overflow
    // S_DONE | session closed, word_count frozen
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL, S_DONE} state_t;

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH:0]   COUNT_MAX = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cursor_q;
    logic [ADDR_WIDTH:0]     count_q;
    logic                    overflow_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    rd_valid_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    wr_fire;

    // A restart in the same cycle drops the offered word.
    assign wr_fire = (state_q == S_LOAD) && wr_valid && !load_start && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cursor_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (load_start) begin
            state_q    <= S_LOAD;
            cursor_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (wr_valid) begin
                        cursor_q <= cursor_q + 1'b1;
                        if (count_q != COUNT_MAX)
                            count_q <= count_q + 1'b1;
                    end
                    if (load_end)
                        state_q <= S_DONE;
                    else if (wr_valid && (cursor_q == LAST_ADDR) && (WRAP_MODE == 0))
                        state_q <= S_FULL;
                end
                S_FULL: begin
                    if (wr_valid)
                        overflow_q <= 1'b1;
                    if (load_end)
                        state_q <= S_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[cursor_q] <= wr_data;
    end

    // Read samples the array before this edge's write lands (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en)
                rd_data_q <= mem[rd_addr];
        end
    end

    assign wr_ready   = (state_q == S_LOAD);
    assign full       = (state_q == S_FULL);
    assign done       = (state_q == S_DONE);
    assign busy       = (state_q == S_LOAD) || (state_q == S_FULL);
    assign overflow   = overflow_q;
    assign word_count = count_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_instr_ram_loader.sv
// Bench for instr_ram_loader: a stop-mode and a wrap-mode instance share one stimulus
// stream and are each compared every cycle against a behavioural session model.
module tb_instr_ram_loader;

    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_FULL = 2;
    localparam int M_DONE = 3;

    logic          clk = 1'b0;
    logic          rst, load_start, load_end, wr_valid, rd_en;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;

    logic [1:0]    wr_ready, rd_valid, full, overflow, done, busy;
    logic [DW-1:0] rd_data    [2];
    logic [AW:0]   word_count [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model, one slot per instance (0 = stop, 1 = wrap).
    int            m_state  [2];
    int            m_cursor [2];
    int            m_cnt    [2];
    bit            m_ovf    [2];
    bit [DW-1:0]   m_mem    [2][DEPTH];
    bit            m_wr     [2][DEPTH];
    bit [DW-1:0]   m_rdd    [2];
    bit            m_rdd_ok [2];
    bit            m_rdv    [2];

    instr_ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRAP_MODE(0)) u_dut_stop (
        .clk(clk), .rst(rst), .load_start(load_start), .load_end(load_end),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready[0]),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
        .word_count(word_count[0]), .full(full[0]), .overflow(overflow[0]),
        .done(done[0]), .busy(busy[0])
    );

    instr_ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRAP_MODE(1)) u_dut_wrap (
        .clk(clk), .rst(rst), .load_start(load_start), .load_end(load_end),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready[1]),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
        .word_count(word_count[1]), .full(full[1]), .overflow(overflow[1]),
        .done(done[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Session rules applied to the inputs sampled at this edge.
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_state[k] = M_IDLE; m_cursor[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
                m_rdd[k] = '0; m_rdd_ok[k] = 1; m_rdv[k] = 0;
                continue;
            end
            m_rdv[k] = rd_en;
            if (rd_en) begin
                m_rdd[k]    = m_mem[k][rd_addr];
                m_rdd_ok[k] = m_wr[k][rd_addr];
            end
            if (load_start) begin
                m_state[k] = M_LOAD; m_cursor[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
            end else if (m_state[k] == M_LOAD) begin
                bit hit_end = 0;
                if (wr_valid) begin
                    m_mem[k][m_cursor[k]] = wr_data;
                    m_wr[k][m_cursor[k]]  = 1;
                    hit_end = (m_cursor[k] == DEPTH - 1) && (k == 0);
                    m_cursor[k] = (m_cursor[k] + 1) % DEPTH;
                    if (m_cnt[k] < DEPTH) m_cnt[k]++;
                end
                if (load_end) m_state[k] = M_DONE;
                else if (hit_end) m_state[k] = M_FULL;
            end else if (m_state[k] == M_FULL) begin
                if (wr_valid) m_ovf[k] = 1;
                if (load_end) m_state[k] = M_DONE;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("u%0d wr_ready", k), 64'(wr_ready[k]), 64'(m_state[k] == M_LOAD));
            check_val($sformatf("u%0d full", k),     64'(full[k]),     64'(m_state[k] == M_FULL));
            check_val($sformatf("u%0d done", k),     64'(done[k]),     64'(m_state[k] == M_DONE));
            check_val($sformatf("u%0d busy", k),     64'(busy[k]),
                      64'((m_state[k] == M_LOAD) || (m_state[k] == M_FULL)));
            check_val($sformatf("u%0d overflow", k), 64'(overflow[k]), 64'(m_ovf[k]));
            check_val($sformatf("u%0d word_count", k), 64'(word_count[k]), 64'(m_cnt[k]));
            check_val($sformatf("u%0d rd_valid", k), 64'(rd_valid[k]), 64'(m_rdv[k]));
            if (m_rdd_ok[k])
                check_val($sformatf("u%0d rd_data", k), 64'(rd_data[k]), 64'(m_rdd[k]));
        end
    endtask

    task automatic cyc(input logic ls, input logic le, input logic v, input logic [DW-1:0] d,
                       input logic re, input logic [AW-1:0] ra, input logic r);
        load_start = ls; load_end = le; wr_valid = v; wr_data = d;
        rd_en = re; rd_addr = ra; rst = r;
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, '0, 0, '0, 0);
    endtask

    task automatic read_cyc(input logic [AW-1:0] ra);
        cyc(0, 0, 0, '0, 1, ra, 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < DEPTH; a++) m_wr[k][a] = 0;

        cyc(0, 0, 0, '0, 0, '0, 1);
        cyc(0, 0, 0, '0, 0, '0, 1);
        check_val("reset word_count", 64'(word_count[0]), 64'd0);
        check_val("reset rd_data", 64'(rd_data[0]), 64'd0);

        // Basic load of four words.
        cyc(1, 0, 0, '0, 0, '0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'hA000_0001 + 32'(i), 0, '0, 0);
        cyc(0, 1, 0, '0, 0, '0, 0);
        check_val("basic word_count", 64'(word_count[0]), 64'd4);
        check_val("basic done", 64'(done[0]), 64'd1);
        for (int i = 0; i < 4; i++) begin
            read_cyc(AW'(i));
            check_val("basic read", 64'(rd_data[0]), 64'(32'hA000_0001 + 32'(i)));
        end

        // Six offers: stop instance fills and overflows, wrap instance overwrites.
        cyc(1, 0, 0, '0, 0, '0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 32'hB000_0000 + 32'(i), 0, '0, 0);
        check_val("stop full", 64'(full[0]), 64'd1);
        check_val("stop overflow", 64'(overflow[0]), 64'd1);
        check_val("stop word_count", 64'(word_count[0]), 64'd4);
        check_val("wrap full", 64'(full[1]), 64'd0);
        check_val("wrap word_count", 64'(word_count[1]), 64'd4);
        read_cyc(2'd0);
        check_val("stop ram0", 64'(rd_data[0]), 64'h0000_0000_B000_0000);
        check_val("wrap ram0", 64'(rd_data[1]), 64'h0000_0000_B000_0004);
        read_cyc(2'd1);
        check_val("wrap ram1", 64'(rd_data[1]), 64'h0000_0000_B000_0005);
        read_cyc(2'd2);
        check_val("wrap ram2", 64'(rd_data[1]), 64'h0000_0000_B000_0002);
        cyc(0, 1, 0, '0, 0, '0, 0);

        // load_end together with a transfer, then start+end together from DONE.
        cyc(1, 0, 0, '0, 0, '0, 0);
        cyc(0, 1, 1, 32'hC0C0_0001, 0, '0, 0);
        check_val("end+xfer done", 64'(done[0]), 64'd1);
        check_val("end+xfer count", 64'(word_count[0]), 64'd1);
        read_cyc(2'd0);
        check_val("end+xfer ram0", 64'(rd_data[0]), 64'h0000_0000_C0C0_0001);
        cyc(1, 0, 0, '0, 0, '0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 32'hD000_0000 + 32'(i), 0, '0, 0);
        cyc(0, 1, 0, '0, 0, '0, 0);
        check_val("pre-restart overflow", 64'(overflow[0]), 64'd1);
        cyc(1, 1, 0, '0, 0, '0, 0);
        check_val("start+end busy", 64'(busy[0]), 64'd1);
        check_val("start+end count", 64'(word_count[0]), 64'd0);
        check_val("start+end overflow", 64'(overflow[0]), 64'd0);

        // Read-during-write on address 0.
        cyc(0, 0, 1, 32'h1234_5678, 0, '0, 0);
        cyc(1, 0, 0, '0, 0, '0, 0);
        cyc(0, 0, 1, 32'hDEAD_BEEF, 1, 2'd0, 0);
        check_val("rdw old", 64'(rd_data[0]), 64'h0000_0000_1234_5678);
        read_cyc(2'd0);
        check_val("rdw new", 64'(rd_data[0]), 64'h0000_0000_DEAD_BEEF);

        // Reset mid-load.
        cyc(1, 0, 0, '0, 0, '0, 0);
        cyc(0, 0, 1, 32'hE000_0000, 0, '0, 0);
        cyc(0, 0, 1, 32'hE000_0001, 0, '0, 0);
        cyc(0, 0, 1, 32'hE000_0002, 0, '0, 1);
        check_val("rst busy", 64'(busy[0]), 64'd0);
        check_val("rst word_count", 64'(word_count[0]), 64'd0);
        check_val("rst wr_ready", 64'(wr_ready[0]), 64'd0);
        read_cyc(2'd1);
        check_val("rst keeps ram1", 64'(rd_data[0]), 64'h0000_0000_E000_0001);
        idle_cyc();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(15) == 0), ($urandom_range(15) == 0), $urandom_range(1) != 0,
                $urandom, $urandom_range(1) != 0, AW'($urandom_range(DEPTH - 1)),
                ($urandom_range(99) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_ram_loader.md
Name: instr_ram_loader

Overview:
- Parametrised instruction-memory loader: accepts a stream of instruction words over a valid/ready handshake and writes them into an internal synchronous RAM at an auto-incrementing cursor.
- Provides load sessions, a full/wrap policy, an overflow flag and a registered read port so the fetch stage can consume the loaded program.
- Sits between the instruction source (assembler/testbench feeder) and the core's fetch logic.

Parameters:
DATA_WIDTH, 32, instruction word width in bits
ADDR_WIDTH, 10, cursor/address width; RAM depth = 2**ADDR_WIDTH words (1024 default)
WRAP_MODE, 0, 0 = stop when full; 1 = cursor wraps to 0 and overwrites

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
load_start  input  1  pulse: begin new load session, cursor := 0
load_end  input  1  pulse: close current session
wr_valid  input  1  instruction word present
wr_data  input  DATA_WIDTH  instruction word
wr_ready  output  1  loader accepts word this cycle
rd_en  input  1  read request
rd_addr  input  ADDR_WIDTH  read address
rd_data  output  DATA_WIDTH  read data, 1-cycle latency
rd_valid  output  1  rd_data valid (rd_en delayed one cycle)
word_count  output  ADDR_WIDTH+1  words written in current session, saturating at 2**ADDR_WIDTH
full  output  1  high in FULL state
overflow  output  1  sticky: word offered while FULL
done  output  1  high in DONE state
busy  output  1  high in LOAD or FULL

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, cursor 0, word_count 0, wr_ready 0, full 0, overflow 0, done 0, busy 0, rd_valid 0, rd_data 0. RAM contents are not cleared.
- States: IDLE, LOAD, FULL, DONE.
  - IDLE/DONE: load_start -> LOAD; cursor, word_count and overflow cleared in the same edge.
  - LOAD: wr_ready=1 (combinational from state). A transfer occurs when wr_valid & wr_ready at an edge: ram[cursor] := wr_data, cursor +1, word_count +1 (saturating).
    - If the transfer writes address 2**ADDR_WIDTH-1 and WRAP_MODE=0: next state FULL.
    - If WRAP_MODE=1: cursor wraps to 0 and state stays LOAD; word_count saturates at 2**ADDR_WIDTH.
  - LOAD, load_end=1: next state DONE. A transfer offered in the same cycle is still accepted and written.
  - FULL: wr_ready=0. wr_valid=1 sets overflow (sticky until load_start or rst). load_end -> DONE.
  - DONE: wr_ready=0; done=1; word_count holds its final value.
  - load_start while in LOAD/FULL: restarts the session (cursor 0, word_count 0, overflow 0, state LOAD). Any transfer offered that cycle is dropped.
  - load_start and load_end asserted together: load_start wins.
- Exactly one RAM write per accepted transfer; no writes outside LOAD.
- Read port: independent of the loader state. On rd_en at edge N, rd_data = ram[rd_addr] and rd_valid = 1 after edge N. rd_data holds its value when rd_en=0; rd_valid=0 in that case.
- Read and write to the same address in the same cycle: rd_data returns the old contents (read-first).
- Reset mid-session: abort immediately and go to IDLE. Words already written remain in RAM.
- Widths: cursor is ADDR_WIDTH bits with natural wrap. word_count is ADDR_WIDTH+1 bits so it can represent a full RAM.

Test Plan:
- Basic load: rst, load_start, stream 4 words 0xA0000001..0xA0000004 with wr_valid continuous, load_end. Expect word_count=4, done=1. Reads of addr 0..3 return those words one cycle after rd_en.
- Backpressure/full (ADDR_WIDTH=2, WRAP_MODE=0): offer 6 words. Expect 4 accepted, full=1 after the 4th, wr_ready=0. The 5th offer sets overflow=1 and word_count stays 4; ram[0] is unchanged.
- Wrap (ADDR_WIDTH=2, WRAP_MODE=1): write 6 words W0..W5. Expect ram[0]=W4, ram[1]=W5, ram[2]=W2; word_count=4 (saturated); full=0.
- Simultaneous events: load_end together with a valid transfer in LOAD writes that word, then done=1. load_start+load_end together from DONE enters LOAD with word_count=0 and overflow cleared.
- Read-during-write: write 0x12345678 to addr 0, then write 0xDEADBEEF to addr 0 while reading addr 0 in the same cycle. Expect rd_data=0x12345678; the next read returns 0xDEADBEEF.
- Reset mid-load: after 2 words, assert rst for 1 cycle. Expect IDLE, busy=0, word_count=0, wr_ready=0. A subsequent read of addr 1 still returns the 2nd word.
